event_reporter: RTL and testbench

- Downstream stage of the glass/shout classifier and the beam-forming direction estimator; upstream of the I2C slave's DATA byte.
- Qualifies the raw per-frame glass/shout flags: consecutive-frame debounce plus per-type re-arm dead time.
- Tags each qualified event with type, sequence number and latest direction, and queues it as one byte.
- Hands bytes out over a valid/ready handshake.

---
 rtl/event_reporter_if.sv | 19 +
 rtl/event_reporter.sv | 131 +++++++++++++
 tb/tb_event_reporter.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_reporter_if.sv
// Byte handshake between the event queue and its consumer.
// The queue drives valid/data; the consumer drives ready.
interface event_reporter_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/event_reporter.sv
// Debounces glass/shout flags, applies per-type re-arm,
// and queues tagged one-byte event records.
module event_reporter #(
  parameter int HOLD_FRAMES  = 4,
  parameter int REARM_CYCLES = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int DIR_WIDTH    = 4,
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 glass,
  input  logic                 shout,
  input  logic                 dir_valid,
  input  logic [DIR_WIDTH-1:0] dir_pattern,
  input  logic                 clear_overflow,
  output logic [PW:0]          pending,
  output logic                 overflow,
  event_reporter_if.master     bus
);

  localparam logic [3:0]  HOLD  = 4'(HOLD_FRAMES);
  localparam logic [15:0] REARM = 16'(REARM_CYCLES);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  logic [1:0] w_flag;
  logic [1:0] w_qual;

  assign w_flag = {shout, glass};

  // Bit 0 is glass, bit 1 is shout; the pair doubles as the record type.
  for (genvar g = 0; g < 2; g++) begin : g_type
    logic [3:0]  r_cnt;
    logic [15:0] r_tmr;

    assign w_qual[g] = frame_tick && w_flag[g] &&
                       (r_cnt == HOLD - 4'd1) &&
                       (r_tmr == 16'd0);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
        r_tmr <= '0;
      end else begin
        if (frame_tick) begin
          if (!w_flag[g])
            r_cnt <= '0;
          else if (r_cnt != HOLD)
            r_cnt <= r_cnt + 4'd1;
        end
        if (w_qual[g])
          r_tmr <= REARM;
        else if (r_tmr != 16'd0)
          r_tmr <= r_tmr - 16'd1;
      end
    end
  end

  logic [DIR_WIDTH-1:0] r_dir;
  logic [1:0]           r_seq;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr;
  logic [PW-1:0]        r_rd;
  logic [PW:0]          r_count;
  logic                 r_ovf;

  logic       w_valid;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_accept;
  logic       w_drop;
  logic [7:0] w_rec;

  assign w_valid  = (r_count != '0);
  assign w_full   = (r_count == DEPTH);
  assign w_push   = |w_qual;
  assign w_pop    = w_valid && bus.byte_ready;
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;
  assign w_rec    = {w_qual[1], w_qual[0], r_seq, r_dir};

  always_ff @(posedge clk) begin
    if (reset)
      r_dir <= '0;
    else if (dir_valid)
      r_dir <= dir_pattern;
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      r_mem[r_wr] <= w_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_seq   <= '0;
    end else begin
      if (w_accept) begin
        r_wr  <= r_wr + 1'b1;
        r_seq <= r_seq + 2'd1;
      end
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      if (w_accept && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_accept && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  // A drop on the same cycle as a clear must still be reported.
  always_ff @(posedge clk) begin
    if (reset)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (clear_overflow)
      r_ovf <= 1'b0;
  end

  assign bus.byte_valid = w_valid;
  assign bus.byte_data  = w_valid ? r_mem[r_rd] : 8'h00;
  assign pending        = r_count;
  assign overflow       = r_ovf;

endmodule

// File: tb/tb_event_reporter.sv
// Directed bench for event_reporter: debounce, re-arm,
// combined type, overflow, full push+pop and reset.
module tb_event_reporter;
  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       glass;
  logic       shout;
  logic       dir_valid;
  logic [3:0] dir_pattern;
  logic       clear_overflow;
  logic [3:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  event_reporter_if bus ();

  event_reporter #(
    .HOLD_FRAMES (4),
    .REARM_CYCLES(100),
    .FIFO_DEPTH  (8),
    .DIR_WIDTH   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .glass         (glass),
    .shout         (shout),
    .dir_valid     (dir_valid),
    .dir_pattern   (dir_pattern),
    .clear_overflow(clear_overflow),
    .pending       (pending),
    .overflow      (overflow),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame tick, then 9 quiet cycles: ticks land 10 clk apart.
  task automatic tick(input logic g, input logic s,
                      input logic dv, input logic [3:0] dp);
    @(negedge clk);
    glass = g;
    shout = s;
    dir_valid = dv;
    dir_pattern = dp;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    dir_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic set_dir(input logic [3:0] d);
    @(negedge clk);
    dir_valid = 1'b1;
    dir_pattern = d;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    glass = 1'b0;
    shout = 1'b0;
    frame_tick = 1'b0;
    dir_valid = 1'b0;
    clear_overflow = 1'b0;
    bus.byte_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.byte_ready = 1'b1;
    @(negedge clk);
    bus.byte_ready = 1'b0;
  endtask

  task automatic event_run(input logic g, input logic s);
    repeat (4) tick(g, s, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    idle(20);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    glass = 1'b0;
    shout = 1'b0;
    dir_valid = 1'b0;
    dir_pattern = 4'h0;
    clear_overflow = 1'b0;
    bus.byte_ready = 1'b0;
    idle(3);
    checks++;
    if (bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b exp 0", bus.byte_valid);
    end
    checks++;
    if (bus.byte_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_data got %h exp 00", bus.byte_data);
    end
    checks++;
    if (pending !== 4'd0) begin
      errors++;
      $display("FAIL rst_pending got %0d exp 0", pending);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_ovf got %b exp 0", overflow);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_debounce();
    set_dir(4'b0010);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (pending !== 4'd0) begin
      errors++;
      $display("FAIL deb_early got %0d exp 0", pending);
    end
    @(negedge clk);
    glass = 1'b1;
    frame_tick = 1'b1;
    checks++;
    if (bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL deb_qcycle got %b exp 0", bus.byte_valid);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    checks++;
    if (bus.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL deb_valid got %b exp 1", bus.byte_valid);
    end
    checks++;
    if (bus.byte_data !== 8'b01_00_0010) begin
      errors++;
      $display("FAIL deb_rec got %h exp 42", bus.byte_data);
    end
    idle(8);
    repeat (20) tick(1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (pending !== 4'd1) begin
      errors++;
      $display("FAIL deb_hold got %0d exp 1", pending);
    end
    pop_one();
    checks++;
    if (pending !== 4'd0 || bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL deb_pop got %0d/%b exp 0/0",
               pending, bus.byte_valid);
    end
    checks++;
    if (bus.byte_data !== 8'h00) begin
      errors++;
      $display("FAIL deb_empty got %h exp 00", bus.byte_data);
    end
    tick(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_glitch();
    repeat (3) tick(1'b0, 1'b1, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++;
    if (pending !== 4'd0 || bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch got %0d/%b exp 0/0",
               pending, bus.byte_valid);
    end
  endtask

  task automatic test_rearm();
    pulse_reset();
    repeat (4) tick(1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (pending !== 4'd1 || bus.byte_data !== 8'h40) begin
      errors++;
      $display("FAIL rearm_first got %0d/%h exp 1/40",
               pending, bus.byte_data);
    end
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    idle(10);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (pending !== 4'd1) begin
      errors++;
      $display("FAIL rearm_block got %0d exp 1", pending);
    end
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    idle(40);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (pending !== 4'd2 || bus.byte_data !== 8'h40) begin
      errors++;
      $display("FAIL rearm_third got %0d/%h exp 2/40",
               pending, bus.byte_data);
    end
    pop_one();
    checks++;
    if (bus.byte_data !== 8'b01_01_0000) begin
      errors++;
      $display("FAIL rearm_seq got %h exp 50", bus.byte_data);
    end
    pop_one();
    tick(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_both();
    idle(100);
    set_dir(4'b1010);
    repeat (3) tick(1'b1, 1'b1, 1'b0, 4'h0);
    tick(1'b1, 1'b1, 1'b1, 4'b0101);
    checks++;
    if (pending !== 4'd1 || bus.byte_data !== 8'b11_10_1010) begin
      errors++;
      $display("FAIL both_rec got %0d/%h exp 1/ea",
               pending, bus.byte_data);
    end
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    idle(120);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (pending !== 4'd2) begin
      errors++;
      $display("FAIL both_next got %0d exp 2", pending);
    end
    pop_one();
    checks++;
    if (bus.byte_data !== 8'b01_11_0101) begin
      errors++;
      $display("FAIL both_seq got %h exp 75", bus.byte_data);
    end
    pop_one();
    tick(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_overflow();
    logic [7:0] rec [8];
    pulse_reset();
    set_dir(4'b0011);
    for (int i = 0; i < 9; i++) begin
      event_run(i % 2 == 0, i % 2 == 1);
      if (i < 8) begin
        logic [1:0] sq;
        sq = 2'(i % 4);
        rec[i] = {(i % 2 == 0) ? 2'b01 : 2'b10, sq, 4'b0011};
      end
    end
    checks++;
    if (pending !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full got %0d/%b exp 8/1",
               pending, overflow);
    end
    bus.byte_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.byte_data !== rec[i]) begin
        errors++;
        $display("FAIL ovf_drain%0d got %h exp %h",
                 i, bus.byte_data, rec[i]);
      end
      @(negedge clk);
    end
    bus.byte_ready = 1'b0;
    checks++;
    if (pending !== 4'd0 || bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty got %0d/%b exp 0/0",
               pending, bus.byte_valid);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b exp 1", overflow);
    end
    @(negedge clk);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b exp 0", overflow);
    end
    idle(100);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (bus.byte_data !== 8'b01_00_0011) begin
      errors++;
      $display("FAIL ovf_seq got %h exp 43", bus.byte_data);
    end
    pop_one();
    tick(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_full_pushpop_reset();
    pulse_reset();
    for (int i = 0; i < 8; i++)
      event_run(i % 2 == 0, i % 2 == 1);
    checks++;
    if (pending !== 4'd8 || bus.byte_data !== 8'h40) begin
      errors++;
      $display("FAIL full_fill got %0d/%h exp 8/40",
               pending, bus.byte_data);
    end
    repeat (3) tick(1'b1, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    glass = 1'b1;
    frame_tick = 1'b1;
    bus.byte_ready = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    bus.byte_ready = 1'b0;
    checks++;
    if (pending !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pp got %0d/%b exp 8/0",
               pending, overflow);
    end
    checks++;
    if (bus.byte_data !== 8'b10_01_0000) begin
      errors++;
      $display("FAIL full_head got %h exp 90", bus.byte_data);
    end
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    pulse_reset();
    checks++;
    if (bus.byte_valid !== 1'b0 || pending !== 4'd0 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got %b/%0d/%b exp 0/0/0",
               bus.byte_valid, pending, overflow);
    end
    repeat (4) tick(1'b0, 1'b1, 1'b0, 4'h0);
    checks++;
    if (bus.byte_data !== 8'b10_00_0000) begin
      errors++;
      $display("FAIL rst_seq got %h exp 80", bus.byte_data);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_rearm();
    test_both();
    test_overflow();
    test_full_pushpop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
